// File: rtl/alu2_arbiter.sv
// alu2_arbiter: round-robin arbiter sharing one 2-bit add/xor datapath
// between NREQ requesters, with a single-entry registered response slot.
// Optional perf counters are built when ALU2_ARB_PERF_EN is defined.

// Shared 2-bit datapath: sel=1 -> (a+b) mod 4, sel=0 -> a^b.
module alu2_dp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       sel,
  output logic [1:0] y
);
  // The add differs from xor only in the carry from bit 0 into bit 1.
  always_comb begin
    y[0] = a[0] ^ b[0];
    y[1] = a[1] ^ b[1] ^ (sel & a[0] & b[0]);
  end
endmodule

module alu2_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_a,
  input  logic [2*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_y,
  output logic              rsp_sel,
  output logic [IDW-1:0]    rsp_id
`ifdef ALU2_ARB_PERF_EN
  ,
  output logic [15:0]       perf_add_cnt,
  output logic [15:0]       perf_xor_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [1:0]     dp_a;
  logic [1:0]     dp_b;
  logic           dp_sel;
  logic [1:0]     dp_y;
  logic           can_accept;
  logic           accept;

  assign rsp_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) || rsp_ready;
  assign accept     = can_accept && gnt_found;

  // Round-robin search starting at ptr; also steers the winner's operands.
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    dp_a      = '0;
    dp_b      = '0;
    dp_sel    = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
        dp_a      = req_a[2*j +: 2];
        dp_b      = req_b[2*j +: 2];
        dp_sel    = req_sel[j];
      end
    end
  end

  // One-hot ready to the winner, only when the slot can take a result.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  alu2_dp u_dp (
    .a   (dp_a),
    .b   (dp_b),
    .sel (dp_sel),
    .y   (dp_y)
  );

  // Slot FSM: load on accept (also covers drain+accept), drain to EMPTY otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ptr     <= '0;
      rsp_y   <= '0;
      rsp_sel <= 1'b0;
      rsp_id  <= '0;
    end else if (accept) begin
      state   <= FULL;
      rsp_y   <= dp_y;
      rsp_sel <= dp_sel;
      rsp_id  <= gnt_idx;
      ptr     <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

`ifdef ALU2_ARB_PERF_EN
  // Saturating per-op accept counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_add_cnt <= '0;
      perf_xor_cnt <= '0;
    end else if (accept) begin
      if (dp_sel && perf_add_cnt != 16'hFFFF) perf_add_cnt <= perf_add_cnt + 16'd1;
      if (!dp_sel && perf_xor_cnt != 16'hFFFF) perf_xor_cnt <= perf_xor_cnt + 16'd1;
    end
  end
`endif

endmodule
